// File: rtl/eth_frame_pipeline.sv
// eth_frame_pipeline
//   AXI4 write-only slave that pushes in-window write beats into a 32-bit
//   payload FIFO, and a framer that emits Ethernet-style frames as a byte
//   AXI-Stream: sync word, dst MAC, src MAC, link type, payload.
//   Also produces a one-shot TX reset pulse and registered GT clock selects.
//   Optional macro ETH_FCS_EN appends a 4-byte CRC-32 after the payload.
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*         AXI4 write channels (size/burst/strb ignored)
//   m_axis_t*               frame byte stream
//   dst_addr..sync_word     header fields, latched at frame start
//   packet_size             payload bytes per frame, 0 keeps the framer idle
//   submodule_en            [0] slave, [1] FIFO (0 = flush), [2] framer
//   reset_after/width       TX reset pulse timing, cycles after reset release
//   tx_rst_o                one-shot TX reset pulse
//   *outclksel_i/_o         registered clock-select pass-through
module eth_frame_pipeline #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [31:0] ADDR_SPAN  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic [47:0] dst_addr,
  input  logic [47:0] src_addr,
  input  logic [15:0] link_type,
  input  logic [15:0] sync_word,
  input  logic [13:0] packet_size,
  input  logic [6:0]  submodule_en,
  input  logic [15:0] reset_after,
  input  logic [15:0] reset_width,
  output logic        tx_rst_o,
  input  logic [2:0]  rxoutclksel_i,
  input  logic [2:0]  txoutclksel_i,
  output logic [2:0]  rxoutclksel_o,
  output logic [2:0]  txoutclksel_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {A_IDLE, A_DATA, A_RESP} astate_t;
`ifdef ETH_FCS_EN
  typedef enum logic [2:0] {F_IDLE, F_SYNC, F_DST, F_SRC, F_TYPE, F_PAY, F_FCS} fstate_t;
`else
  typedef enum logic [2:0] {F_IDLE, F_SYNC, F_DST, F_SRC, F_TYPE, F_PAY} fstate_t;
`endif

  logic          w_unused;
  assign w_unused = ^{s_axi_awlen, s_axi_wstrb, submodule_en[6:3]};

  // ---------------- FIFO ----------------
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full, w_push, w_pop, w_pop_fifo;
  logic [31:0]   w_head;

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop_fifo = w_pop && (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_axi_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!submodule_en[1]) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop_fifo})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- AXI write slave ----------------
  astate_t     r_astate, w_anext;
  logic        r_awready, r_decerr;
  logic [31:0] r_addr;
  logic [1:0]  r_bresp;
  logic        w_beat_in, w_whs;

  assign w_beat_in     = (r_addr - BASE_ADDR) < ADDR_SPAN;
  // A full FIFO still accepts a beat when the framer pops in the same cycle.
  assign s_axi_wready  = (r_astate == A_DATA) && (!w_beat_in || !w_full || w_pop_fifo);
  assign w_whs         = s_axi_wvalid && s_axi_wready;
  assign w_push        = w_whs && w_beat_in && submodule_en[1];
  assign s_axi_awready = r_awready;
  assign s_axi_bvalid  = (r_astate == A_RESP);
  assign s_axi_bresp   = r_bresp;

  always_comb begin
    w_anext = r_astate;
    case (r_astate)
      A_IDLE:  if (r_awready && s_axi_awvalid) w_anext = A_DATA;
      A_DATA:  if (w_whs && s_axi_wlast)       w_anext = A_RESP;
      A_RESP:  if (s_axi_bready)               w_anext = A_IDLE;
      default: w_anext = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_astate  <= A_IDLE;
      r_awready <= 1'b0;
      r_decerr  <= 1'b0;
      r_addr    <= '0;
      r_bresp   <= 2'b00;
    end else begin
      r_astate  <= w_anext;
      r_awready <= (r_astate == A_IDLE) && !r_awready && s_axi_awvalid && submodule_en[0];
      if (r_astate == A_IDLE && r_awready && s_axi_awvalid) begin
        r_addr   <= s_axi_awaddr;
        r_decerr <= 1'b0;
      end
      if (w_whs) begin
        r_addr <= r_addr + 32'd4;
        if (!w_beat_in) r_decerr <= 1'b1;
        if (s_axi_wlast) r_bresp <= (r_decerr || !w_beat_in) ? 2'b11 : 2'b00;
      end
    end
  end

  // ---------------- Framer ----------------
  fstate_t      r_fstate, w_fnext;
  logic [127:0] r_hdr;     // sync, dst, src, type; shifted out MSB first
  logic [13:0]  r_psize, r_pcnt;
  logic [3:0]   r_idx;
  logic         w_start, w_hs, w_pay_last;
  logic [7:0]   w_tdata, w_pay_byte;
  logic         w_tvalid, w_tlast;
  logic [14:0]  w_need;

  assign w_need     = ({1'b0, packet_size} + 15'd3) >> 2;
  assign w_hs       = (r_fstate != F_IDLE) && m_axis_tready;
  assign w_pay_last = (r_pcnt == r_psize - 14'd1);

  always_comb begin
    case (r_pcnt[1:0])
      2'd0:    w_pay_byte = w_head[7:0];
      2'd1:    w_pay_byte = w_head[15:8];
      2'd2:    w_pay_byte = w_head[23:16];
      default: w_pay_byte = w_head[31:24];
    endcase
  end

`ifdef ETH_FCS_EN
  logic [31:0] r_crc, w_fcs;
  assign w_fcs = ~r_crc;

  function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_crc <= '1;
    else if (w_start) r_crc <= '1;
    else if (w_hs && (r_fstate inside {F_DST, F_SRC, F_TYPE, F_PAY}))
      r_crc <= f_crc8(r_crc, w_tdata);
  end
`endif

  always_comb begin
    w_fnext  = r_fstate;
    w_tvalid = 1'b0;
    w_tdata  = '0;
    w_tlast  = 1'b0;
    w_pop    = 1'b0;
    w_start  = 1'b0;
    case (r_fstate)
      F_IDLE: begin
        if (packet_size != '0 && submodule_en[2] && 15'(r_count) >= w_need) begin
          w_start = 1'b1;
          w_fnext = F_SYNC;
        end
      end
      F_SYNC, F_DST, F_SRC, F_TYPE: begin
        w_tvalid = 1'b1;
        w_tdata  = r_hdr[127:120];
        if (w_hs) begin
          if (r_fstate == F_SYNC && r_idx == 4'd1)  w_fnext = F_DST;
          if (r_fstate == F_DST  && r_idx == 4'd7)  w_fnext = F_SRC;
          if (r_fstate == F_SRC  && r_idx == 4'd13) w_fnext = F_TYPE;
          if (r_fstate == F_TYPE && r_idx == 4'd15) w_fnext = F_PAY;
        end
      end
      F_PAY: begin
        w_tvalid = 1'b1;
        w_tdata  = w_pay_byte;
`ifndef ETH_FCS_EN
        w_tlast  = w_pay_last;
`endif
        if (w_hs) begin
          w_pop = (r_pcnt[1:0] == 2'd3) || w_pay_last;
`ifdef ETH_FCS_EN
          if (w_pay_last) w_fnext = F_FCS;
`else
          if (w_pay_last) w_fnext = F_IDLE;
`endif
        end
      end
`ifdef ETH_FCS_EN
      F_FCS: begin
        w_tvalid = 1'b1;
        case (r_idx[1:0])
          2'd0:    w_tdata = w_fcs[7:0];
          2'd1:    w_tdata = w_fcs[15:8];
          2'd2:    w_tdata = w_fcs[23:16];
          default: w_tdata = w_fcs[31:24];
        endcase
        w_tlast = (r_idx[1:0] == 2'd3);
        if (w_hs && r_idx[1:0] == 2'd3) w_fnext = F_IDLE;
      end
`endif
      default: w_fnext = F_IDLE;
    endcase
  end

  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = w_tdata;
  assign m_axis_tlast  = w_tlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fstate <= F_IDLE;
      r_hdr    <= '0;
      r_psize  <= '0;
      r_pcnt   <= '0;
      r_idx    <= '0;
    end else begin
      r_fstate <= w_fnext;
      if (w_start) begin
        r_hdr   <= {sync_word, dst_addr, src_addr, link_type};
        r_psize <= packet_size;
        r_pcnt  <= '0;
        r_idx   <= '0;
      end else if (w_hs) begin
        // r_idx wraps 15 -> 0 at the end of the header, so it is 0 again for FCS.
        if (r_fstate == F_PAY) r_pcnt <= r_pcnt + 14'd1;
        else begin
          r_hdr <= {r_hdr[119:0], 8'h00};
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

  // ---------------- TX reset pulse and clock selects ----------------
  logic [31:0] r_cyc, w_cyc_nxt;
  logic        r_tx_rst, w_in_pulse;
  logic [2:0]  r_rxsel, r_txsel;

  assign w_cyc_nxt  = (r_cyc == '1) ? r_cyc : r_cyc + 32'd1;
  // Saturating counter: the window can only be crossed once per reset.
  assign w_in_pulse = ({1'b0, w_cyc_nxt} >= {17'b0, reset_after}) &&
                      ({1'b0, w_cyc_nxt} < ({17'b0, reset_after} + {17'b0, reset_width}));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cyc    <= '0;
      r_tx_rst <= 1'b0;
      r_rxsel  <= 3'b000;
      r_txsel  <= 3'b000;
    end else begin
      r_cyc    <= w_cyc_nxt;
      r_tx_rst <= w_in_pulse;
      r_rxsel  <= rxoutclksel_i;
      r_txsel  <= txoutclksel_i;
    end
  end

  assign tx_rst_o      = r_tx_rst;
  assign rxoutclksel_o = r_rxsel;
  assign txoutclksel_o = r_txsel;
endmodule

// File: tb/tb_eth_frame_pipeline.sv
module tb_eth_frame_pipeline;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
  logic [47:0] dst_addr = 48'hDEAD_BEEF_CAFE;
  logic [47:0] src_addr = 48'hCAFE_BABE_2024;
  logic [15:0] link_type = 16'h1337;
  logic [15:0] sync_word = 16'hB00B;
  logic [13:0] packet_size = '0;
  logic [6:0]  submodule_en = 7'b0000011;
  logic [15:0] reset_after = 16'h0100;
  logic [15:0] reset_width = 16'd5;
  logic        tx_rst_o;
  logic [2:0]  rxoutclksel_i = 3'b101, txoutclksel_i = 3'b011;
  logic [2:0]  rxoutclksel_o, txoutclksel_o;

  eth_frame_pipeline dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .dst_addr(dst_addr), .src_addr(src_addr), .link_type(link_type), .sync_word(sync_word),
    .packet_size(packet_size), .submodule_en(submodule_en),
    .reset_after(reset_after), .reset_width(reset_width), .tx_rst_o(tx_rst_o),
    .rxoutclksel_i(rxoutclksel_i), .txoutclksel_i(txoutclksel_i),
    .rxoutclksel_o(rxoutclksel_o), .txoutclksel_o(txoutclksel_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected {tlast, tdata} bytes and a model of the payload FIFO.
  logic [8:0]  exp_q[$];
  logic [31:0] fifo_q[$];
  bit          mon_en = 1'b1;
  int          tr_mode = 0;   // 0: always ready, 1: random, 2: toggle

  // Cycle k after reset release is sampled on the negedge following posedge k.
  int cyc_k = 0, p_hi = 0, p_first = 0, p_last = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      cyc_k = 0; p_hi = 0; p_first = 0; p_last = 0;
    end else begin
      cyc_k++;
      if (tx_rst_o) begin
        if (p_hi == 0) p_first = cyc_k;
        p_last = cyc_k;
        p_hi++;
      end
      if (mon_en && m_axis_tvalid) begin
        if (exp_q.size() == 0)
          check("stray_tvalid", 32'(m_axis_tvalid), 32'd0);
        else begin
          check("stream_byte", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, exp_q[0]});
          if (m_axis_tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        2:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

`ifdef ETH_FCS_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction
`endif

  task automatic push_frame(input int psize);
    logic [127:0] h;
    logic [31:0]  w, c;
    logic [7:0]   b;
    bit           lst;
    h = {sync_word, dst_addr, src_addr, link_type};
    c = '1;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b = h[127-8*i -: 8];
      exp_q.push_back({1'b0, b});
`ifdef ETH_FCS_EN
      if (i >= 2) c = crc_upd(c, b);
`endif
    end
    for (int i = 0; i < psize; i++) begin
      if (i % 4 == 0) w = fifo_q.pop_front();
      b = w[8*(i%4) +: 8];
      lst = (i == psize - 1);
`ifdef ETH_FCS_EN
      c = crc_upd(c, b);
      lst = 1'b0;
`endif
      exp_q.push_back({lst, b});
    end
`ifdef ETH_FCS_EN
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), c[8*i +: 8]});
`endif
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] exp_resp, input string tag);
    int n;
    @(posedge clk); #1;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    for (n = 0; n < 100; n++) begin @(negedge clk); if (s_axi_awready) break; end
    check({tag, "_awready"}, 32'(s_axi_awready), 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = d; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    for (n = 0; n < 400; n++) begin @(negedge clk); if (s_axi_wready) break; end
    check({tag, "_wready"}, 32'(s_axi_wready), 32'd1);
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    for (n = 0; n < 100; n++) begin @(negedge clk); if (s_axi_bvalid) break; end
    check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_eval(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (cyc_k >= 300) break;
      @(negedge clk);
    end
    check({tag, "_count"}, 32'(p_hi), 32'd5);
    check({tag, "_first"}, 32'(p_first), 32'd256);
    check({tag, "_last"},  32'(p_last), 32'd260);
  endtask

  task automatic set_en(input int bit_idx, input logic v);
    @(posedge clk); #1;
    submodule_en[bit_idx] = v;
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready",  32'(s_axi_wready), 32'd0);
    check("rst_bvalid",  32'(s_axi_bvalid), 32'd0);
    check("rst_bresp",   32'(s_axi_bresp), 32'd0);
    check("rst_tvalid",  32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",   32'(m_axis_tdata), 32'd0);
    check("rst_tlast",   32'(m_axis_tlast), 32'd0);
    check("rst_txrst",   32'(tx_rst_o), 32'd0);
    check("rst_clksel",  {26'd0, rxoutclksel_o, txoutclksel_o}, 32'd0);
    #2 resetn = 1'b1;
    @(negedge clk);
    check("clksel_pass", {26'd0, rxoutclksel_o, txoutclksel_o}, {26'd0, 3'b101, 3'b011});

    // Test 1: single word, 4-byte payload.
    axi_write(32'h2000_0000, 32'hB00B_CAFE, 2'b00, "t1_wr");
    fifo_q.push_back(32'hB00B_CAFE);
    push_frame(4);
    packet_size = 14'd4;
    set_en(2, 1'b1);
    wait_drain("t1", 200);
    set_en(2, 1'b0);

    // Test 2: 23-byte payload with a backpressured stream, 5 words left over.
    packet_size = 14'd23;
    axi_write(32'h2000_0000, 32'hB00B_CAFE, 2'b00, "t2_wr0");
    fifo_q.push_back(32'hB00B_CAFE);
    for (int i = 1; i <= 10; i++) begin
      axi_write(32'h2000_0000 + 32'(4*i), 32'hBEEF_1337, 2'b00, "t2_wr");
      fifo_q.push_back(32'hBEEF_1337);
    end
    tr_mode = 1;
    push_frame(23);
    set_en(2, 1'b1);
    wait_drain("t2", 600);
    repeat (40) @(negedge clk);
    check("t2_no_second_frame", 32'(m_axis_tvalid), 32'd0);
    set_en(2, 1'b0);
    tr_mode = 0;

    // Test 4: out-of-window writes are dropped; the boundary word is kept.
    axi_write(32'h3000_0000, 32'h1111_1111, 2'b11, "t4_far");
    axi_write(32'h2000_1000, 32'h2222_2222, 2'b11, "t4_top");
    axi_write(32'h1FFF_FFFC, 32'h3333_3333, 2'b11, "t4_below");
    packet_size = 14'd24;
    set_en(2, 1'b1);
    repeat (30) @(negedge clk);
    check("t4_no_frame", 32'(m_axis_tvalid), 32'd0);
    fifo_q.push_back(32'hA5A5_5A5A);
    push_frame(24);
    axi_write(32'h2000_0FFC, 32'hA5A5_5A5A, 2'b00, "t4_edge");
    wait_drain("t4", 300);
    set_en(2, 1'b0);

    // Test 3: TX reset pulse timing.
    pulse_eval("t3_pulse");

    // Test 5: FIFO full backpressure, push+pop at full, framer enable dropped mid-frame.
    packet_size = 14'd4;
    for (int i = 0; i < 16; i++) begin
      axi_write(32'h2000_0000 + 32'(4*i), 32'h1000 + 32'(i), 2'b00, "t5_fill");
      fifo_q.push_back(32'h1000 + 32'(i));
    end
    fork
      axi_write(32'h2000_0040, 32'h2000, 2'b00, "t5_17th");
      begin
        repeat (10) @(negedge clk);
        check("t5_wready_full", 32'(s_axi_wready), 32'd0);
        fifo_q.push_back(32'h2000);
        push_frame(4);
        set_en(2, 1'b1);
        set_en(2, 1'b0);
      end
    join
    wait_drain("t5", 200);
    repeat (10) @(negedge clk);
    check("t5_single_frame", 32'(m_axis_tvalid), 32'd0);
    set_en(1, 1'b0);
    set_en(1, 1'b1);
    fifo_q.delete();

    // Test 6: toggling tready, reset mid-payload.
    for (int i = 0; i < 4; i++) begin
      axi_write(32'h2000_0000 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 2'b00, "t6_wr");
      fifo_q.push_back(32'hC0DE_0000 + 32'(i));
    end
    push_frame(16);
    packet_size = 14'd16;
    tr_mode = 2;
    set_en(2, 1'b1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (exp_q.size() <= 8) break;
    end
    check("t6_mid_payload", 32'(exp_q.size() <= 8), 32'd1);
    #2;
    resetn = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    @(negedge clk);
    check("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_rst_tlast",  32'(m_axis_tlast), 32'd0);
    check("t6_rst_txrst",  32'(tx_rst_o), 32'd0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    mon_en = 1'b1;
    pulse_eval("t6_pulse");
    check("t6_no_resume", 32'(m_axis_tvalid), 32'd0);
    tr_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
